fetch_warp_scheduler: RTL
=========================

# fetch_warp_scheduler

Round-robin warp scheduler for the compute-unit fetcher. Each cycle it picks one eligible warp from the per-warp ITS status (ready, PC, active mask, subwarp id), pulses that warp's select line back to the ITS stage, and registers the fetch request into a single-entry valid/ready output register toward instruction memory. A per-warp pending flag limits each warp to one fetch in flight until the decode stage reports that fetch's instruction as decoded.

## Interface
- PcWidth, 32, program counter width
- NumWarps, 32, warps per compute unit (>=1)
- WarpWidth, 32, threads per warp (>=1)
- WidWidth, NumWarps>1 ? $clog2(NumWarps) : 1, derived, do not override
- SubwarpIdWidth, WarpWidth>1 ? $clog2(WarpWidth) : 1, derived, do not override

Ports:
- clk_i  in  1  clock; single clock domain, all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- warp_ready_i  in  NumWarps  warp can be fetched this cycle
- warp_pc_i  in  NumWarps x PcWidth  PC per warp
- warp_act_mask_i  in  NumWarps x WarpWidth  active mask per warp
- warp_subwarp_id_i  in  NumWarps x SubwarpIdWidth  subwarp id per warp
- warp_selected_o  out  NumWarps  one-hot select pulse back to the ITS stage
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  instruction memory accepts request
- imem_req_pc_o  out  PcWidth  fetch PC
- imem_req_wid_o  out  WidWidth  warp id
- imem_req_act_mask_o  out  WarpWidth  active mask
- imem_req_subwarp_id_o  out  SubwarpIdWidth  subwarp id
- decode_done_i  in  1  an instruction was decoded
- decode_wid_i  in  WidWidth  warp of the decoded instruction
- pending_o  out  NumWarps  per-warp fetch-in-flight flags, for debug and verification

## Operation
- eligible[w] = warp_ready_i[w] & ~pending_q[w] & (|warp_act_mask_i[w]).
- can_issue = ~imem_req_valid_o | imem_req_ready_i. The output register is empty, or it is draining this cycle.
- Arbitration applies only when can_issue and at least one warp is eligible. Search starts at rr_q, runs upward, and wraps modulo NumWarps. The first eligible warp w is granted.
- On a grant to w, all of the following happen:
  - warp_selected_o[w]=1 combinationally in the same cycle. All other bits are 0.
  - The output register loads {pc, act_mask, subwarp_id, w} of warp w, and valid_q is set to 1.
  - pending_q[w] is set to 1.
  - rr_q is set to (w+1) mod NumWarps. With NumWarps=1, rr_q stays 0.
- With no grant: valid_q is cleared if imem_req_ready_i drains the register, otherwise it holds. Payload and rr_q hold.
- While valid is asserted, the payload is stable and valid stays high until imem_req_ready_i is seen.
- When decode_done_i is high, pending_q[decode_wid_i] is cleared at the next edge. If decode_wid_i is out of range, nothing changes.
- Set and clear of the same warp in the same cycle: set wins. This cannot occur legally, because a pending warp is not eligible.
- In the reset cycle, warp_selected_o is forced to 0.

## Timing
- Reset values (sampled at an edge with rst_i=1), visible from the next cycle:
  - imem_req_valid_o=0
  - imem_req_pc_o, imem_req_act_mask_o, imem_req_subwarp_id_o, imem_req_wid_o all '0
  - pending_q all 0
  - rr_q=0
  - warp_selected_o=0
- Reset asserted mid-request discards the held request. There is no replay. Pending flags clear.
- Select pulse to request valid: 1 cycle. Grant in cycle t means imem_req_valid_o=1 with that payload from t+1.
- Throughput: 1 request per cycle while imem_req_ready_i stays high. Back-to-back grants go to different warps only, since a granted warp is pending.
- Decode in cycle t makes the warp eligible again from t+1. There is no same-cycle bypass.
- Backpressure: with imem_req_ready_i=0 and valid=1, no grant is made and warp_selected_o=0.

## Test plan
- Reset then idle: NumWarps=4, rst_i=1 for 2 cycles, all warp_ready_i=0 -> valid=0, pending_o=0000, warp_selected_o=0000 every cycle.
- Round-robin with ready always high: warp_ready_i=1111, all masks nonzero, decode_done_i echoes each wid 1 cycle after its request is accepted -> grant order 0,1,2,3,0,... and each imem_req_wid_o matches the select of the previous cycle.
- Backpressure: warp 2 granted (PC=0x40), imem_req_ready_i=0 for 3 cycles -> payload PC=0x40, wid=2 held stable with valid=1, no further select pulses; ready=1 drains it and a new grant occurs in that same cycle.
- Pending gating: warp 1 granted, warp_ready_i[1] kept 1, no decode -> warp 1 never reselected. decode_done_i with wid=1 at cycle t -> warp 1 selectable at t+1, not at t.
- Zero-mask filter and wrap: rr_q=3, warp_ready_i=1001 with act_mask[3]=0 -> warp 0 granted and rr_q becomes 1.
- Reset mid-request: valid=1, pending_o=0110, rst_i=1 for 1 cycle -> next cycle valid=0, pending_o=0000, rr_q=0, and the first post-reset grant goes to the lowest eligible warp.

Source files
------------

// File: rtl/fetch_warp_scheduler.sv
// Round-robin warp scheduler for the compute-unit fetcher: picks one eligible warp per
// cycle, pulses its select line and registers the fetch request toward instruction memory.
module fetch_warp_scheduler #(
  parameter int PcWidth        = 32,
  parameter int NumWarps       = 32,
  parameter int WarpWidth      = 32,
  parameter int WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  parameter int SubwarpIdWidth = (WarpWidth > 1) ? $clog2(WarpWidth) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumWarps-1:0]                      warp_ready_i,
  input  logic [NumWarps-1:0][PcWidth-1:0]         warp_pc_i,
  input  logic [NumWarps-1:0][WarpWidth-1:0]       warp_act_mask_i,
  input  logic [NumWarps-1:0][SubwarpIdWidth-1:0]  warp_subwarp_id_i,
  output logic [NumWarps-1:0]                      warp_selected_o,
  output logic                                     imem_req_valid_o,
  input  logic                                     imem_req_ready_i,
  output logic [PcWidth-1:0]                       imem_req_pc_o,
  output logic [WidWidth-1:0]                      imem_req_wid_o,
  output logic [WarpWidth-1:0]                     imem_req_act_mask_o,
  output logic [SubwarpIdWidth-1:0]                imem_req_subwarp_id_o,
  input  logic                                     decode_done_i,
  input  logic [WidWidth-1:0]                      decode_wid_i,
  output logic [NumWarps-1:0]                      pending_o
);

  // imem request handshake: a transfer happens on a rising edge where valid and ready are
  // both high; once valid rises, payload is frozen and valid stays high until that transfer.

  logic [NumWarps-1:0]       pending_q, pending_d;
  logic [WidWidth-1:0]       rr_q, rr_d;
  logic                      valid_q, valid_d;
  logic [PcWidth-1:0]        pc_q, pc_d;
  logic [WidWidth-1:0]       wid_q, wid_d;
  logic [WarpWidth-1:0]      mask_q, mask_d;
  logic [SubwarpIdWidth-1:0] sub_q, sub_d;

  logic [NumWarps-1:0]       eligible;
  logic                      can_issue;
  logic                      grant_vld;
  logic [WidWidth-1:0]       grant_wid;
  int                        scan_idx;
  logic [WidWidth-1:0]       scan_wid;

  assign can_issue = ~valid_q | imem_req_ready_i;

  always_comb begin
    eligible = '0;
    for (int w = 0; w < NumWarps; w++) begin
      eligible[w] = warp_ready_i[w] & ~pending_q[w] & (|warp_act_mask_i[w]);
    end
  end

  // Rotating priority search starting at rr_q; rr_q is always < NumWarps, so one
  // conditional subtract implements the wrap without a divider.
  always_comb begin
    grant_vld = 1'b0;
    grant_wid = '0;
    scan_idx  = 0;
    scan_wid  = '0;
    if (can_issue) begin
      for (int i = 0; i < NumWarps; i++) begin
        scan_idx = int'(rr_q) + i;
        if (scan_idx >= NumWarps) begin
          scan_idx = scan_idx - NumWarps;
        end
        scan_wid = WidWidth'(scan_idx);
        if (!grant_vld && eligible[scan_wid]) begin
          grant_vld = 1'b1;
          grant_wid = scan_wid;
        end
      end
    end
  end

  always_comb begin
    warp_selected_o = '0;
    if (grant_vld && !rst_i) begin
      warp_selected_o[grant_wid] = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (int'(grant_wid) == NumWarps - 1) ? '0 : grant_wid + 1'b1;
    end
  end

  // Decode clear first, then grant set, so a same-warp collision resolves to set.
  always_comb begin
    pending_d = pending_q;
    for (int w = 0; w < NumWarps; w++) begin
      if (decode_done_i && (decode_wid_i == WidWidth'(w))) begin
        pending_d[w] = 1'b0;
      end
    end
    if (grant_vld) begin
      pending_d[grant_wid] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    wid_d   = wid_q;
    mask_d  = mask_q;
    sub_d   = sub_q;
    if (grant_vld) begin
      valid_d = 1'b1;
      pc_d    = warp_pc_i[grant_wid];
      wid_d   = grant_wid;
      mask_d  = warp_act_mask_i[grant_wid];
      sub_d   = warp_subwarp_id_i[grant_wid];
    end else if (imem_req_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      rr_q      <= '0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      wid_q     <= '0;
      mask_q    <= '0;
      sub_q     <= '0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      wid_q     <= wid_d;
      mask_q    <= mask_d;
      sub_q     <= sub_d;
    end
  end

  assign imem_req_valid_o      = valid_q;
  assign imem_req_pc_o         = pc_q;
  assign imem_req_wid_o        = wid_q;
  assign imem_req_act_mask_o   = mask_q;
  assign imem_req_subwarp_id_o = sub_q;
  assign pending_o             = pending_q;

endmodule
